// File: rtl/stopwatch_display_master_if.sv
// AXI4-Lite write-only channel bundle between the stopwatch and its display slave.
// Read channels are intentionally absent.
interface stopwatch_display_master_if #(
  parameter int AW = 7
);
  logic [AW-1:0] M_AXI_AWADDR;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY;
  logic [2:0]    M_AXI_AWPROT;
  logic [31:0]   M_AXI_WDATA;
  logic [3:0]    M_AXI_WSTRB;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP;
  logic          M_AXI_BVALID;
  logic          M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/stopwatch_display_master.sv
// BCD stopwatch (mmmm:ss:hh) that mirrors its elapsed time to a display slave
// over AXI4-Lite, coalescing updates so at most one write is ever outstanding.
package stopwatch_display_master_pkg;
  // Ripple BCD increment; digit 3 (tens of seconds) rolls over at 5, all others at 9.
  function automatic logic [31:0] bcd_inc(input logic [31:0] t);
    logic [31:0] r;
    logic        c;
    logic [3:0]  lim;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lim = (i == 3) ? 4'd5 : 4'd9;
      if (c) begin
        if (r[4*i +: 4] == lim) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
endpackage

module stopwatch_display_master #(
  parameter int          AW           = 7,
  parameter int          CLK_FREQ_HZ  = 100000000,
  parameter logic [31:0] DISP_BASE    = 32'd0,
  parameter logic [31:0] FORMAT_VALUE = 32'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        running,
  output logic [31:0] elapsed,
  output logic        busy,
  output logic        error,
  stopwatch_display_master_if.master m_axi
);
  import stopwatch_display_master_pkg::*;

  localparam int            PRESCALE      = CLK_FREQ_HZ / 100;
  localparam logic [31:0]   PRESCALE_LAST = 32'(PRESCALE - 1);
  localparam logic [AW-1:0] FMT_ADDR      = AW'(DISP_BASE + 32'h10);
  localparam logic [AW-1:0] TIME_ADDR     = AW'(DISP_BASE + 32'h04);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_ADDR = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]    state_r, state_nxt_s;
  logic [31:0]   prescale_r, prescale_nxt_s;
  logic          running_r, running_nxt_s;
  logic [31:0]   elapsed_r, elapsed_nxt_s;
  logic          pending_r, pending_nxt_s;
  logic          error_r, error_nxt_s;
  logic          busy_r, busy_nxt_s;
  logic [AW-1:0] awaddr_r, awaddr_nxt_s;
  logic          awvalid_r, awvalid_nxt_s;
  logic [31:0]   wdata_r, wdata_nxt_s;
  logic          wvalid_r, wvalid_nxt_s;
  logic          bready_r, bready_nxt_s;
  logic          tick_s, change_s, take_s, aw_ok_s, w_ok_s;

  // Next-state logic for the timebase, the BCD counter and the write FSM.
  always_comb begin
    tick_s        = running_r && (prescale_r == PRESCALE_LAST);
    running_nxt_s = stop ? 1'b0 : (start ? 1'b1 : running_r);

    if (clear || start || tick_s) begin
      prescale_nxt_s = 32'd0;
    end else if (running_r) begin
      prescale_nxt_s = prescale_r + 32'd1;
    end else begin
      prescale_nxt_s = prescale_r;
    end

    // clear outranks a coincident tick
    if (clear) begin
      elapsed_nxt_s = 32'd0;
    end else if (tick_s) begin
      elapsed_nxt_s = bcd_inc(elapsed_r);
    end else begin
      elapsed_nxt_s = elapsed_r;
    end
    change_s = clear ? (elapsed_r != 32'd0) : tick_s;

    state_nxt_s   = state_r;
    awaddr_nxt_s  = awaddr_r;
    wdata_nxt_s   = wdata_r;
    awvalid_nxt_s = awvalid_r;
    wvalid_nxt_s  = wvalid_r;
    bready_nxt_s  = bready_r;
    error_nxt_s   = error_r;
    take_s        = 1'b0;
    aw_ok_s       = !awvalid_r || m_axi.M_AXI_AWREADY;
    w_ok_s        = !wvalid_r || m_axi.M_AXI_WREADY;

    case (state_r)
      ST_INIT: begin
        awaddr_nxt_s  = FMT_ADDR;
        wdata_nxt_s   = FORMAT_VALUE;
        awvalid_nxt_s = 1'b1;
        wvalid_nxt_s  = 1'b1;
        state_nxt_s   = ST_ADDR;
      end
      ST_IDLE: begin
        if (pending_r) begin
          awaddr_nxt_s  = TIME_ADDR;
          wdata_nxt_s   = elapsed_r;
          awvalid_nxt_s = 1'b1;
          wvalid_nxt_s  = 1'b1;
          take_s        = 1'b1;
          state_nxt_s   = ST_ADDR;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (aw_ok_s && w_ok_s) begin
          awvalid_nxt_s = 1'b0;
          wvalid_nxt_s  = 1'b0;
          bready_nxt_s  = 1'b1;
          state_nxt_s   = ST_RESP;
        end else begin
          awvalid_nxt_s = awvalid_r && !m_axi.M_AXI_AWREADY;
          wvalid_nxt_s  = wvalid_r && !m_axi.M_AXI_WREADY;
        end
      end
      ST_RESP: begin
        if (m_axi.M_AXI_BVALID && bready_r) begin
          bready_nxt_s = 1'b0;
          error_nxt_s  = error_r || (m_axi.M_AXI_BRESP != 2'b00);
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s  = ST_RESP;
        end
      end
      default: begin
        awvalid_nxt_s = 1'b0;
        wvalid_nxt_s  = 1'b0;
        bready_nxt_s  = 1'b0;
        state_nxt_s   = ST_INIT;
      end
    endcase

    // a change arriving while the FSM consumes pending re-arms it for the next write
    pending_nxt_s = (pending_r && !take_s) || change_s;
    busy_nxt_s    = (state_nxt_s != ST_IDLE) || pending_nxt_s;
  end

  // State registers; reset abandons any open transaction at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_INIT;
      prescale_r <= 32'd0;
      running_r  <= 1'b0;
      elapsed_r  <= 32'd0;
      pending_r  <= 1'b0;
      error_r    <= 1'b0;
      busy_r     <= 1'b1;
      awaddr_r   <= {AW{1'b0}};
      awvalid_r  <= 1'b0;
      wdata_r    <= 32'd0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      prescale_r <= prescale_nxt_s;
      running_r  <= running_nxt_s;
      elapsed_r  <= elapsed_nxt_s;
      pending_r  <= pending_nxt_s;
      error_r    <= error_nxt_s;
      busy_r     <= busy_nxt_s;
      awaddr_r   <= awaddr_nxt_s;
      awvalid_r  <= awvalid_nxt_s;
      wdata_r    <= wdata_nxt_s;
      wvalid_r   <= wvalid_nxt_s;
      bready_r   <= bready_nxt_s;
    end
  end

  assign running              = running_r;
  assign elapsed              = elapsed_r;
  assign busy                 = busy_r;
  assign error                = error_r;
  assign m_axi.M_AXI_AWADDR   = awaddr_r;
  assign m_axi.M_AXI_AWVALID  = awvalid_r;
  assign m_axi.M_AXI_AWPROT   = 3'b000;
  assign m_axi.M_AXI_WDATA    = wdata_r;
  assign m_axi.M_AXI_WSTRB    = 4'hF;
  assign m_axi.M_AXI_WVALID   = wvalid_r;
  assign m_axi.M_AXI_BREADY   = bready_r;
endmodule

// File: tb/tb_stopwatch_display_master.sv
// Directed bench for stopwatch_display_master: a delay-programmable AXI slave
// feeds a scoreboard of expected display writes.
module tb_stopwatch_display_master;
  localparam logic [6:0]  FMT_ADDR  = 7'h10;
  localparam logic [6:0]  TIME_ADDR = 7'h04;
  localparam logic [31:0] FMT_VAL   = 32'h5A5A_0003;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        running, busy, error;
  logic [31:0] elapsed;

  int checks = 0;
  int errors = 0;
  int cs = 0;
  wr_t exp_q[$];

  int         aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0] bresp_cfg = 2'b00;

  stopwatch_display_master_if #(.AW(7)) axi ();

  stopwatch_display_master #(
    .AW(7), .CLK_FREQ_HZ(1000), .DISP_BASE(32'd0), .FORMAT_VALUE(FMT_VAL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .clear(clear),
    .running(running), .elapsed(elapsed), .busy(busy), .error(error),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input int c);
    int h, s, m;
    h = c % 100;
    s = (c / 100) % 60;
    m = (c / 6000) % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic s_start, input logic s_stop, input logic s_clear);
    @(negedge clk);
    start = s_start; stop = s_stop; clear = s_clear;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Runs exactly n ticks from a stopped state, expecting one display write per tick.
  task automatic run_ticks(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back({TIME_ADDR, to_bcd(cs + i)});
    cmd(1'b1, 1'b0, 1'b0);
    repeat (n * 10) @(posedge clk);
    cmd(1'b0, 1'b1, 1'b0);
    cs += n;
    wait_idle();
  endtask

  // Slave model: decisions made on the falling edge, handshakes land on the next rising edge.
  initial begin
    int aw_cnt, w_cnt, b_cnt;
    bit aw_arm, w_arm, b_arm, aw_acc, w_acc;
    logic [6:0]  cap_addr;
    logic [31:0] cap_data;
    wr_t e;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_arm = 0; w_arm = 0; b_arm = 0; aw_acc = 0; w_acc = 0;
    cap_addr = 7'h00; cap_data = 32'h0;
    axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0;
    axi.M_AXI_BVALID = 1'b0; axi.M_AXI_BRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_arm = 0; w_arm = 0; b_arm = 0; aw_acc = 0; w_acc = 0;
        axi.M_AXI_AWREADY = 1'b0; axi.M_AXI_WREADY = 1'b0; axi.M_AXI_BVALID = 1'b0;
      end else begin
        if (aw_arm) aw_acc = 1;
        if (w_arm) w_acc = 1;
        if (b_arm) begin
          aw_acc = 0; w_acc = 0; b_cnt = 0;
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_extra_write addr=%h data=%h expected no write", cap_addr, cap_data);
          end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            assert ({cap_addr, cap_data} === {e.addr, e.data}) else begin
              errors++;
              $error("FAIL sb_write observed addr=%h data=%h expected addr=%h data=%h",
                     cap_addr, cap_data, e.addr, e.data);
            end
          end
        end
        if (axi.M_AXI_AWVALID) begin
          if (aw_cnt >= aw_wait) axi.M_AXI_AWREADY = 1'b1;
          else begin axi.M_AXI_AWREADY = 1'b0; aw_cnt++; end
        end else begin
          axi.M_AXI_AWREADY = 1'b0; aw_cnt = 0;
        end
        if (axi.M_AXI_WVALID) begin
          if (w_cnt >= w_wait) axi.M_AXI_WREADY = 1'b1;
          else begin axi.M_AXI_WREADY = 1'b0; w_cnt++; end
        end else begin
          axi.M_AXI_WREADY = 1'b0; w_cnt = 0;
        end
        if (aw_acc && w_acc) begin
          if (b_cnt >= b_wait) begin axi.M_AXI_BVALID = 1'b1; axi.M_AXI_BRESP = bresp_cfg; end
          else begin axi.M_AXI_BVALID = 1'b0; b_cnt++; end
        end else begin
          axi.M_AXI_BVALID = 1'b0;
        end
        aw_arm = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
        if (aw_arm) cap_addr = axi.M_AXI_AWADDR;
        w_arm = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
        if (w_arm) cap_data = axi.M_AXI_WDATA;
        b_arm = axi.M_AXI_BVALID && axi.M_AXI_BREADY;
      end
    end
  end

  initial begin
    int n, aw_hi, w_hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_elapsed", elapsed, 32'd0);
    chk("rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    chk("rst_wvalid", 32'(axi.M_AXI_WVALID), 32'd0);
    chk("rst_bready", 32'(axi.M_AXI_BREADY), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Format write issued on the first edge after reset release
    exp_q.push_back({FMT_ADDR, FMT_VAL});
    resetn = 1'b1;
    @(negedge clk);
    chk("fmt_awvalid", 32'(axi.M_AXI_AWVALID), 32'd1);
    chk("fmt_wvalid", 32'(axi.M_AXI_WVALID), 32'd1);
    chk("fmt_awaddr", 32'(axi.M_AXI_AWADDR), 32'h10);
    chk("awprot", 32'(axi.M_AXI_AWPROT), 32'd0);
    chk("wstrb", 32'(axi.M_AXI_WSTRB), 32'hF);
    wait_idle();
    chk("fmt_error", 32'(error), 32'd0);

    // One second of counting
    run_ticks(100);
    chk("one_second", elapsed, 32'h0000_0100);
    chk("stopped", 32'(running), 32'd0);

    // Seconds-to-minutes carry, then BCD helper boundaries
    run_ticks(5899);
    chk("preload_5999", elapsed, 32'h0000_5999);
    run_ticks(1);
    chk("minute_carry", elapsed, 32'h0001_0000);
    chk("wrap_full", stopwatch_display_master_pkg::bcd_inc(32'h9999_5999), 32'h0000_0000);
    chk("carry_1000min", stopwatch_display_master_pkg::bcd_inc(32'h0999_5999), 32'h1000_0000);

    // AWREADY held off for 5 cycles, WREADY immediate
    aw_wait = 5;
    exp_q.push_back({TIME_ADDR, to_bcd(cs + 1)});
    cmd(1'b1, 1'b0, 1'b0);
    n = 0;
    while (axi.M_AXI_AWVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("aw_seen", 32'(axi.M_AXI_AWVALID), 32'd1);
    aw_hi = 0; w_hi = 0; n = 0;
    while ((axi.M_AXI_AWVALID === 1'b1 || axi.M_AXI_WVALID === 1'b1) && n < 40) begin
      if (axi.M_AXI_AWVALID === 1'b1) begin
        aw_hi++;
        chk("awaddr_stable", 32'(axi.M_AXI_AWADDR), 32'h04);
      end
      if (axi.M_AXI_WVALID === 1'b1) begin
        w_hi++;
        chk("wdata_stable", axi.M_AXI_WDATA, to_bcd(cs + 1));
      end
      chk("bready_early", 32'(axi.M_AXI_BREADY), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("wvalid_cycles", 32'(w_hi), 32'd1);
    chk("awvalid_cycles", 32'(aw_hi), 32'd6);
    cmd(1'b0, 1'b1, 1'b0);
    cs += 1;
    aw_wait = 0;
    wait_idle();
    chk("after_slow_aw", elapsed, to_bcd(cs));

    // Slow BVALID: five ticks coalesce into one write carrying the latest value
    b_wait = 50;
    exp_q.push_back({TIME_ADDR, to_bcd(cs + 1)});
    exp_q.push_back({TIME_ADDR, to_bcd(cs + 6)});
    cmd(1'b1, 1'b0, 1'b0);
    repeat (64) @(posedge clk);
    cmd(1'b0, 1'b1, 1'b0);
    cs += 6;
    wait_idle();
    b_wait = 0;
    chk("coalesced_elapsed", elapsed, to_bcd(cs));
    chk("okay_no_error", 32'(error), 32'd0);

    // DECERR on a clear-triggered write; error is sticky
    bresp_cfg = 2'b11;
    exp_q.push_back({TIME_ADDR, 32'd0});
    cmd(1'b0, 1'b0, 1'b1);
    cs = 0;
    wait_idle();
    chk("decerr_error", 32'(error), 32'd1);
    bresp_cfg = 2'b00;
    run_ticks(1);
    chk("error_sticky", 32'(error), 32'd1);

    // start alone sets running; start+stop together: stop wins
    cmd(1'b1, 1'b0, 1'b0);
    chk("start_runs", 32'(running), 32'd1);
    cmd(1'b1, 1'b1, 1'b0);
    chk("stop_wins", 32'(running), 32'd0);

    // clear on the tick edge: clear wins
    exp_q.push_back({TIME_ADDR, 32'd0});
    cmd(1'b1, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("clear_wins", elapsed, 32'd0);
    cs = 0;
    wait_idle();

    // Reset in the middle of an address phase
    aw_wait = 10; w_wait = 10;
    cmd(1'b1, 1'b0, 1'b0);
    n = 0;
    while (axi.M_AXI_AWVALID !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("mid_aw_seen", 32'(axi.M_AXI_AWVALID), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    chk("async_wvalid", 32'(axi.M_AXI_WVALID), 32'd0);
    chk("async_bready", 32'(axi.M_AXI_BREADY), 32'd0);
    chk("async_running", 32'(running), 32'd0);
    chk("async_elapsed", elapsed, 32'd0);
    repeat (3) @(negedge clk);
    aw_wait = 0; w_wait = 0;
    exp_q.push_back({FMT_ADDR, FMT_VAL});
    resetn = 1'b1;
    wait_idle();
    chk("reset_clears_error", 32'(error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_display_master.md
STOPWATCH_DISPLAY_MASTER -- requirements
Module: stopwatch_display_master

Interface
REQ-001 AW, 7, width of M_AXI_AWADDR in bits.
REQ-002 CLK_FREQ_HZ, 100000000, clk frequency; hundredths prescale is CLK_FREQ_HZ/100 cycles.
REQ-003 DISP_BASE, 0, byte base address of the display register slave.
REQ-004 FORMAT_VALUE, 0, data written to the display format register (offset 0x10) after reset.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 resetn  in  1  reset, asynchronous and active-low.
REQ-007 start, stop, clear  in  1 each  single-cycle command pulses.
REQ-008 running  out  1  1 = counting.
REQ-009 elapsed  out  32  BCD time: [31:16] minutes 0000-9999, [15:8] seconds 00-59, [7:0] hundredths 00-99.
REQ-010 busy  out  1  1 = AXI write in flight or pending.
REQ-011 error  out  1  sticky; set by any non-OKAY BRESP.
REQ-012 M_AXI_AWADDR out AW, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1, M_AXI_AWPROT out 3 (constant 0).
REQ-013 M_AXI_WDATA out 32, M_AXI_WSTRB out 4 (constant 0xF), M_AXI_WVALID out 1, M_AXI_WREADY in 1.
REQ-014 M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.

Function
REQ-015 The prescaler SHALL count 0..CLK_FREQ_HZ/100-1 while running and emit a one-cycle tick on terminal count.
REQ-016 Each tick SHALL increment elapsed as BCD: hundredths 99->00 carries to seconds, seconds 59->00 carries to minutes, 9999:59:99 wraps to 0000:00:00.
REQ-017 start SHALL set running and zero the prescaler; stop SHALL clear running; stop and start in the same cycle: stop wins.
REQ-018 clear SHALL zero elapsed and the prescaler in the next cycle, regardless of running; running is unaffected except by start/stop; clear coincident with a tick: clear wins.
REQ-019 Every change of elapsed (tick or clear of a nonzero value) SHALL set a pending flag.
REQ-020 FSM states: INIT, IDLE, ADDR, RESP.
REQ-021 INIT: issue write of FORMAT_VALUE to DISP_BASE+0x10, then go to ADDR.
REQ-022 IDLE: if pending, latch elapsed into WDATA, AWADDR = DISP_BASE+0x04, clear pending, go to ADDR.
REQ-023 ADDR: AWVALID and WVALID SHALL assert together; each SHALL drop independently on the cycle after its VALID&READY; when both accepted, go to RESP.
REQ-024 AWADDR/WDATA SHALL be stable while the corresponding VALID is high.
REQ-025 RESP: BREADY high; on BVALID, set error if BRESP != 0, go to IDLE (from the format write: IDLE as well).
REQ-026 Changes during ADDR/RESP SHALL only set pending (coalescing); the next write carries the latest elapsed, never a stale value.
REQ-027 busy = (state != IDLE) or pending.
REQ-028 At most one AXI transaction outstanding; no read channels implemented.

Reset
REQ-029 resetn low SHALL asynchronously force: running 0, elapsed 0, prescaler 0, pending 0, error 0, AWVALID 0, WVALID 0, BREADY 0, state INIT.
REQ-030 AWVALID/WVALID for the format write SHALL assert on the first clk rising edge after resetn deasserts.
REQ-031 Reset during an open transaction SHALL abandon it immediately; no VALID held after reset.

Verification (CLK_FREQ_HZ=1000, prescale 10, DISP_BASE=0)
REQ-032 Release reset, slave ready -> AW 0x10, WDATA=FORMAT_VALUE, BRESP OKAY, then idle, busy 0, error 0.
REQ-033 start, 1000 cycles -> elapsed 0x00000100 (1.00 s); writes to 0x04 observed, last WDATA 0x00000100.
REQ-034 Preload 0x00005999 via run, one tick -> 0x00010000; at 9999:59:99 one tick -> 0x00000000.
REQ-035 AWREADY low 5 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held stable 5 cycles, BREADY only after both accepted.
REQ-036 BVALID delayed 50 cycles while running -> one coalesced write follows carrying current elapsed; BRESP=DECERR -> error stays 1 until reset.
REQ-037 start+stop same cycle -> running 0; clear+tick same cycle -> elapsed 0; resetn low mid-ADDR -> all VALIDs 0 asynchronously.
